alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage between the 32x32 register file's read ports and its write port.
//  - Consumes two read operands (read1/read2) plus an opcode and destination address.
//  - Computes single-cycle ALU results, or runs a 32-cycle iterative shift-add multiply.
//  - Drives the register file write side directly:
//    wb_en->write_cntrl, wb_addr->writeaddr, wb_data->write_data.
// PARAMETERS
//  DW    32  operand/result width
//  AW     5  register address width
//  MULC  32  multiply iterations (= DW)
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  clr        in   1   synchronous, active-high reset
//  in_valid   in   1   opcode/operands/rd_addr valid this cycle
//  in_ready   out  1   stage can accept; transfer when in_valid&&in_ready at posedge
//  op         in   3   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL
//  rs1_data   in   DW  operand A (register file read1)
//  rs2_data   in   DW  operand B (register file read2)
//  rd_addr    in   AW  destination register
//  wb_en      out  1   one-cycle write strobe to register file
//  wb_addr    out  AW  destination address, valid while wb_en
//  wb_data    out  DW  result, valid while wb_en
//  busy       out  1   high while in MUL state
// BEHAVIOUR
//  - Reset (clr=1 at posedge):
//    - state=IDLE, wb_en=0, wb_addr=0, wb_data=0, busy=0, iteration counter=0.
//    - Mid-MUL reset: the operation is dropped; no wb_en pulse is ever issued for it.
//    - in_ready=1 in the first cycle after the reset edge.
//  - FSM, two states: IDLE, MUL. in_ready = (state==IDLE) (combinational from state).
//  - IDLE:
//    - On transfer of op!=MUL at edge k: wb_en=1, wb_addr=rd_addr, wb_data=result, registered at k.
//    - Latency 1 cycle. wb_en is high for exactly the cycle after edge k.
//    - Back-to-back transfers give a wb_en pulse every cycle.
//  - IDLE, MUL transfer at edge k:
//    - Latch A=rs1_data, B=rs2_data, rd_addr; acc=0; cnt=0; go to MUL.
//    - wb_en=0 after edge k.
//  - MUL, each edge:
//    - if B[0] then acc+=A; A<<=1; B>>=1; cnt++.
//    - On the edge where cnt reaches MULC (edge k+32): wb_en=1, wb_data=acc (incl. final add), wb_addr=latched rd.
//    - Return to IDLE on that same edge.
//    - MUL latency is 32 cycles; in_ready low from after edge k through edge k+32.
//  - Inputs presented while in_ready=0 are ignored; the upstream source holds them.
//  - wb_en deasserts on the next edge unless a new single-cycle transfer occurs.
//  - Arithmetic, all results truncated to DW (no flags):
//    - ADD/SUB wrap modulo 2^DW.
//    - SLT: signed compare, result 1 or 0.
//    - SLL: shift by rs2_data[4:0].
//    - MUL: low DW bits of the unsigned product; signed operands give correct low bits.
//  - rd_addr=0 is written like any other address; register-0 policy belongs to the register file.
//  - Operand hazards: none handled here. Upstream stalls, or reads after wb_en, to see new values.
// TESTING
//  1 clr pulse -> next cycle wb_en=0, wb_data=0, in_ready=1, busy=0.
//  2 ADD rs1=25 rs2=28 rd=16 -> following cycle wb_en=1, wb_addr=16, wb_data=53; wb_en=0 the cycle after.
//  3 Back-to-back SUB 5-7 rd=3, then SLT 0xFFFFFFFF,1 rd=4
//    -> consecutive pulses: (3, 0xFFFFFFFE) then (4, 1).
//  4 MUL 25*28 rd=9 -> in_ready=0 and busy=1 for 32 cycles, one wb_en pulse with wb_addr=9, wb_data=700.
//    - A second in_valid held during the MUL is accepted only after in_ready returns to 1.
//  5 MUL 0x00010000*0x00010000 -> wb_data=0 (truncation).
//    - SLL 1 by rs2=0x23 -> wb_data=8 (shift amount uses the low 5 bits).
//  6 MUL started, clr asserted 10 cycles later -> no wb_en pulse at any time afterward.
//    - in_ready=1 the cycle after clr; a new ADD completes normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage sitting between the register file read ports and its write
// port. Single-cycle ALU operations write back one cycle after acceptance;
// MUL runs a 32-iteration shift-add loop and writes back when it finishes.
//
// Handshake: a request (op, rs1_data, rs2_data, rd_addr) transfers on a
// rising edge where in_valid && in_ready are both high. in_ready depends only
// on the FSM state, never on in_valid. While in_ready is low the upstream
// source holds its request stable, and this stage ignores it.
//
// Ports
//   clk       rising-edge clock
//   clr       synchronous active-high reset
//   in_valid  request present this cycle
//   in_ready  stage can accept (state == IDLE)
//   op        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//             110 SLL, 111 MUL
//   rs1_data  operand A
//   rs2_data  operand B
//   rd_addr   destination register
//   wb_en     one-cycle write strobe to the register file
//   wb_addr   destination address, valid while wb_en
//   wb_data   result, valid while wb_en
//   busy      high while the FSM is in MUL; doubles as the state observation
//             point (busy == (state == ST_MUL))
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int MULC = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  input  logic [AW-1:0] rd_addr,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          busy
);

  localparam int CW = $clog2(MULC + 1);
  localparam int SW = $clog2(DW);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_lat;

  logic          xfer;
  logic          mul_start;
  logic          mul_last;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] acc_next;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_MUL);
  assign xfer      = in_valid && in_ready;
  assign mul_start = xfer && (op == OP_MUL);
  // Edge on which the counter moves from MULC-1 to MULC: the final iteration.
  assign mul_last  = (state == ST_MUL) && (cnt == CW'(MULC - 1));
  // Accumulator including this edge's conditional add, so the final add is
  // folded into the written-back result.
  assign acc_next  = acc + (mul_b[0] ? mul_a : '0);

  // Single-cycle ALU.
  always_comb begin
    alu_result = '0;
    unique case (op)
      OP_ADD:  alu_result = rs1_data + rs2_data;
      OP_SUB:  alu_result = rs1_data - rs2_data;
      OP_AND:  alu_result = rs1_data & rs2_data;
      OP_OR:   alu_result = rs1_data | rs2_data;
      OP_XOR:  alu_result = rs1_data ^ rs2_data;
      OP_SLT:  alu_result = {{(DW-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
      OP_SLL:  alu_result = rs1_data << rs2_data[SW-1:0];
      OP_MUL:  alu_result = '0;
      default: alu_result = '0;
    endcase
  end

  // FSM next state.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Multiplier datapath.
  always_ff @(posedge clk) begin
    if (clr) begin
      mul_a  <= '0;
      mul_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      rd_lat <= '0;
    end else if (mul_start) begin
      mul_a  <= rs1_data;
      mul_b  <= rs2_data;
      acc    <= '0;
      cnt    <= '0;
      rd_lat <= rd_addr;
    end else if (state == ST_MUL) begin
      acc   <= acc_next;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

  // Write-back register. wb_addr/wb_data hold their last value when wb_en is
  // low; only the strobe is a pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (mul_last) begin
      wb_en   <= 1'b1;
      wb_addr <= rd_lat;
      wb_data <= acc_next;
    end else if (xfer && !mul_start) begin
      wb_en   <= 1'b1;
      wb_addr <= rd_addr;
      wb_data <= alu_result;
    end else begin
      wb_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Directed bench for alu_exec_stage. Each task drives one scenario and checks
// its own results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic          clk;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [AW-1:0] rd_addr;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.DW(DW), .AW(AW), .MULC(32)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Present a request at the falling edge, return 1 time unit after the
  // following rising edge (the transfer edge when in_ready was high).
  task automatic send(input logic [2:0] o, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [AW-1:0] rd);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a wb_en pulse, at most max_cyc edges. Reports whether one was
  // seen and after how many edges.
  task automatic wait_wb(input int max_cyc, output bit found, output int cyc);
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wb_en) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wb_en, wb_addr, wb_data, in_ready, busy} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: wb_en=%0b wb_addr=%0d wb_data=%h in_ready=%0b busy=%0b, want 0 0 0 1 0",
               wb_en, wb_addr, wb_data, in_ready, busy);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_add();
    send(OP_ADD, 32'd25, 32'd28, 5'd16);
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd16, 32'd53}) begin
      errors++;
      $display("FAIL add: wb_en=%0b addr=%0d data=%0d, want 1 16 53", wb_en, wb_addr, wb_data);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL add_deassert: wb_en=%0b, want 0", wb_en);
    end
  endtask

  task automatic test_back_to_back();
    send(OP_SUB, 32'd5, 32'd7, 5'd3);
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL b2b_sub: wb_en=%0b addr=%0d data=%h, want 1 3 fffffffe", wb_en, wb_addr, wb_data);
    end
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4);
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd4, 32'd1}) begin
      errors++;
      $display("FAIL b2b_slt: wb_en=%0b addr=%0d data=%h, want 1 4 1", wb_en, wb_addr, wb_data);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_deassert: wb_en=%0b, want 0", wb_en);
    end
  endtask

  // Logic ops and the other SLT sense, issued back to back from a table.
  task automatic test_logic_ops();
    logic [2:0]    t_op  [5];
    logic [DW-1:0] t_a   [5];
    logic [DW-1:0] t_b   [5];
    logic [DW-1:0] t_exp [5];
    t_op[0] = OP_AND; t_a[0] = 32'h0000_F0F0; t_b[0] = 32'h0000_FF00; t_exp[0] = 32'h0000_F000;
    t_op[1] = OP_OR;  t_a[1] = 32'h0000_F0F0; t_b[1] = 32'h0000_FF00; t_exp[1] = 32'h0000_FFF0;
    t_op[2] = OP_XOR; t_a[2] = 32'h0000_F0F0; t_b[2] = 32'h0000_FF00; t_exp[2] = 32'h0000_0FF0;
    t_op[3] = OP_SLT; t_a[3] = 32'd1;         t_b[3] = 32'hFFFF_FFFF; t_exp[3] = 32'd0;
    t_op[4] = OP_SLL; t_a[4] = 32'h8000_0001; t_b[4] = 32'd4;         t_exp[4] = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      send(t_op[i], t_a[i], t_b[i], AW'(20 + i));
      checks++;
      if ({wb_en, wb_addr, wb_data} !== {1'b1, AW'(20 + i), t_exp[i]}) begin
        errors++;
        $display("FAIL logic_op%0d: wb_en=%0b addr=%0d data=%h, want 1 %0d %h",
                 i, wb_en, wb_addr, wb_data, 20 + i, t_exp[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mul();
    int  busy_cycles;
    bit  done;
    send(OP_MUL, 32'd25, 32'd28, 5'd9);
    checks++;
    if ({in_ready, busy, wb_en} !== 3'b010) begin
      errors++;
      $display("FAIL mul_start: in_ready=%0b busy=%0b wb_en=%0b, want 0 1 0", in_ready, busy, wb_en);
    end
    busy_cycles = 1;
    // A second request arrives and is held while the multiply runs.
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_ADD;
    rs1_data = 32'd1;
    rs2_data = 32'd2;
    rd_addr  = 5'd5;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (wb_en) begin
        done = 1'b1;
        checks++;
        if ({wb_addr, wb_data, in_ready, busy} !== {5'd9, 32'd700, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL mul_result: addr=%0d data=%0d in_ready=%0b busy=%0b, want 9 700 1 0",
                   wb_addr, wb_data, in_ready, busy);
        end
      end else if (busy && !in_ready) begin
        busy_cycles++;
      end else begin
        done = 1'b1;
        checks++;
        errors++;
        $display("FAIL mul_early_idle: in_ready=%0b busy=%0b after %0d busy cycles, want still busy",
                 in_ready, busy, busy_cycles);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL mul_timeout: no wb_en within 40 cycles, want pulse");
    end
    checks++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL mul_busy_len: busy cycles=%0d, want 32", busy_cycles);
    end
    // The held ADD transfers on the first edge with in_ready high.
    @(posedge clk);
    #1;
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd5, 32'd3}) begin
      errors++;
      $display("FAIL mul_held_add: wb_en=%0b addr=%0d data=%0d, want 1 5 3", wb_en, wb_addr, wb_data);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("FAIL mul_held_deassert: wb_en=%0b, want 0", wb_en);
    end
  endtask

  task automatic test_truncation();
    bit found;
    int cyc;
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd7);
    idle_inputs();
    wait_wb(40, found, cyc);
    checks++;
    if (!found || cyc != 32 || wb_addr !== 5'd7 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL mul_trunc: found=%0b cyc=%0d addr=%0d data=%h, want 1 32 7 0",
               found, cyc, wb_addr, wb_data);
    end
    // -3 * 5 = -15: low bits of a signed product.
    send(OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd12);
    idle_inputs();
    wait_wb(40, found, cyc);
    checks++;
    if (!found || cyc != 32 || wb_addr !== 5'd12 || wb_data !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mul_signed: found=%0b cyc=%0d addr=%0d data=%h, want 1 32 12 fffffff1",
               found, cyc, wb_addr, wb_data);
    end
    send(OP_SLL, 32'd1, 32'h0000_0023, 5'd8);
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd8, 32'd8}) begin
      errors++;
      $display("FAIL sll_mask: wb_en=%0b addr=%0d data=%h, want 1 8 8", wb_en, wb_addr, wb_data);
    end
    idle_inputs();
  endtask

  task automatic test_mul_abort();
    int early_pulses;
    bit found;
    int cyc;
    send(OP_MUL, 32'd25, 32'd28, 5'd10);
    idle_inputs();
    early_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (wb_en) early_pulses++;
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, wb_en, early_pulses != 0} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%0b busy=%0b wb_en=%0b early_pulses=%0d, want 1 0 0 0",
               in_ready, busy, wb_en, early_pulses);
    end
    @(negedge clk);
    clr = 1'b0;
    wait_wb(40, found, cyc);
    checks++;
    if (found) begin
      errors++;
      $display("FAIL abort_no_wb: wb_en seen after %0d cycles addr=%0d data=%h, want none",
               cyc, wb_addr, wb_data);
    end
    send(OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd11);
    checks++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd11, 32'd1}) begin
      errors++;
      $display("FAIL abort_add: wb_en=%0b addr=%0d data=%h, want 1 11 1", wb_en, wb_addr, wb_data);
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    op       = 3'b000;
    rs1_data = '0;
    rs2_data = '0;
    rd_addr  = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_ops();
    test_mul();
    test_truncation();
    test_mul_abort();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
